// File: rtl/npc_lsu.sv
// npc_lsu: single-outstanding load/store unit.
// A request is captured in IDLE, checked for alignment, issued to memory as
// one aligned XLEN-wide beat with a byte mask, and answered with aligned and
// extended load data. A cycle budget bounds the ISSUE+WAIT phases.
module npc_lsu #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [OW-1:0]   r_off;

  logic [OW-1:0]   a_off;
  logic            a_mis;
  logic [7:0]      a_bmask;
  logic [NB-1:0]   a_wmask;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld;
  logic            to_hit;

  // Accept-time decode of the incoming request: byte offset, alignment, lane mask
  always_comb begin
    a_off   = req_addr[OW-1:0];
    a_mis   = 1'b0;
    a_bmask = 8'h01;
    case (req_size)
      2'd0: a_bmask = 8'h01;
      2'd1: begin a_bmask = 8'h03; a_mis = req_addr[0]; end
      2'd2: begin a_bmask = 8'h0f; a_mis = |req_addr[1:0]; end
      default: begin
        a_bmask = 8'hff;
        // double-word accesses do not exist on a 32-bit data path
        a_mis   = (XLEN == 32) ? 1'b1 : |req_addr[2:0];
      end
    endcase
    a_wmask = NB'(a_bmask) << a_off;
  end

  // Load data alignment: shift the addressed bytes down, then extend
  always_comb begin
    sh = mem_rdata >> {r_off, 3'b000};
    ld = sh;
    case (r_size)
      2'd0: ld = r_uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'd1: ld = r_uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'd2: ld = r_uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: ld = sh;
    endcase
  end

  assign to_hit = (cnt == TO_LAST);

  // Control FSM; every output is a register so nothing on req_* reaches mem_* combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_err   <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_off      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready comes up one edge after reset release, then tracks IDLE
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            r_size    <= req_size;
            r_uns     <= req_unsigned;
            r_off     <= a_off;
            resp_rd   <= req_rd;
            if (a_mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 2'd1;
              resp_rdata <= '0;
            end else begin
              state     <= ISSUE;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[AW-1:OW], OW'(0)};
              mem_wdata <= req_we ? (req_wdata << {a_off, 3'b000}) : '0;
              mem_wmask <= req_we ? a_wmask : '0;
            end
          end
        end
        ISSUE: begin
          // a timeout aborts even if memory accepts in the same cycle
          if (to_hit) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 2'd3;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            if (mem_ready) begin
              mem_valid <= 1'b0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // a completion beats a timeout landing in the same cycle
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= mem_err ? 2'd2 : 2'd0;
            resp_rdata <= (mem_err || mem_we) ? '0 : ld;
          end else if (to_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd3;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npc_lsu.sv
// Scoreboard bench for npc_lsu: a 32-bit instance (TIMEOUT=4) with a memory
// responder, and a 64-bit instance driven directly.
module tb_npc_lsu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  npc_lsu #(.XLEN(32), .AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err));

  // 64-bit instance
  logic        d_req_valid, d_req_ready, d_req_we, d_req_unsigned;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [4:0]  d_req_rd;
  logic        d_resp_valid, d_resp_ready;
  logic [63:0] d_resp_rdata;
  logic [4:0]  d_resp_rd;
  logic [1:0]  d_resp_err;
  logic        d_mem_valid, d_mem_ready, d_mem_we, d_mem_rvalid, d_mem_err;
  logic [31:0] d_mem_addr;
  logic [63:0] d_mem_wdata, d_mem_rdata;
  logic [7:0]  d_mem_wmask;

  npc_lsu #(.XLEN(64), .AW(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we), .req_size(d_req_size),
    .req_unsigned(d_req_unsigned), .req_addr(d_req_addr), .req_wdata(d_req_wdata), .req_rd(d_req_rd),
    .resp_valid(d_resp_valid), .resp_ready(d_resp_ready), .resp_rdata(d_resp_rdata),
    .resp_rd(d_resp_rd), .resp_err(d_resp_err),
    .mem_valid(d_mem_valid), .mem_ready(d_mem_ready), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_wdata(d_mem_wdata), .mem_wmask(d_mem_wmask),
    .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata), .mem_err(d_mem_err));

  typedef struct {logic [31:0] rdata; logic [4:0] rd; logic [1:0] err; int lat; int t0;} exp_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wmask;} cmd_t;
  typedef struct {logic [63:0] rdata; logic [1:0] err;} exp64_t;

  exp_t   sb[$];
  cmd_t   memq[$];
  exp64_t sb64[$];
  int pass_n = 0, tot_n = 0;

  // memory responder knobs
  logic        cfg_ready, cfg_err;
  int          cfg_delay;
  logic [31:0] cfg_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory responder for the 32-bit instance: checks each presented command
  // against the expected queue and returns read data after cfg_delay cycles
  initial begin
    bit pend;
    int dly;
    cmd_t c;
    pend = 0; dly = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      if (!reset) pend = 0;
      else begin
        if (pend) begin
          if (dly == 0) begin
            mem_rvalid = 1; mem_rdata = cfg_rdata; mem_err = cfg_err; pend = 0;
          end else dly--;
        end
        if (mem_valid) begin
          if (memq.size() == 0) chk("unexpected mem_valid", 1, 0);
          else begin
            c = memq[0];
            chk("mem_addr", mem_addr, c.addr);
            chk("mem_we", mem_we, c.we);
            chk("mem_wdata", mem_wdata, c.wdata);
            chk("mem_wmask", mem_wmask, c.wmask);
            if (mem_ready) begin
              void'(memq.pop_front());
              pend = 1; dly = cfg_delay;
            end
          end
        end
      end
      mem_ready = cfg_ready;
    end
  end

  // Response monitor for the 32-bit instance: checks on first sight, re-checks
  // one cycle later for stability, then accepts
  initial begin
    bit held;
    exp_t e;
    held = 0;
    resp_ready = 0;
    forever begin
      @(negedge clk);
      resp_ready = 0;
      if (!reset) held = 0;
      else if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected resp_valid", 1, 0);
          resp_ready = 1;
        end else begin
          e = sb[0];
          if (!held) begin
            chk("latency", cyc - e.t0, e.lat);
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_rd", resp_rd, e.rd);
            chk("resp_err", resp_err, e.err);
            chk("mem_valid in RESP", mem_valid, 0);
            held = 1;
          end else begin
            chk("resp held", {resp_rdata, resp_rd, resp_err}, {e.rdata, e.rd, e.err});
            resp_ready = 1;
            void'(sb.pop_front());
            held = 0;
          end
        end
      end
    end
  end

  // Response monitor for the 64-bit instance
  initial begin
    exp64_t e;
    d_resp_ready = 0;
    forever begin
      @(negedge clk);
      d_resp_ready = 0;
      if (reset && d_resp_valid) begin
        if (sb64.size() == 0) chk("d unexpected resp_valid", 1, 0);
        else begin
          e = sb64.pop_front();
          chk("d resp_rdata", d_resp_rdata, e.rdata);
          chk("d resp_err", d_resp_err, e.err);
        end
        d_resp_ready = 1;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] erd, input logic [1:0] eerr, input int lat,
                       input bit mem, input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic [3:0] mwm, input bit resp);
    int n;
    exp_t e;
    cmd_t c;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready wait", req_ready, 1);
    if (mem) begin
      c.addr = maddr; c.we = we; c.wdata = mwd; c.wmask = mwm;
      memq.push_back(c);
    end
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 0;
    if (resp) begin
      e.rdata = erd; e.rd = rd; e.err = eerr; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
      n = 0;
      while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
      if (sb.size() != 0) chk("response wait", sb.size(), 0);
    end
  endtask

  task automatic issue64(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] erd, input logic [1:0] eerr, input bit mem,
                         input logic [31:0] maddr, input logic [63:0] mwd,
                         input logic [7:0] mwm, input logic [63:0] mrd);
    int n;
    exp64_t e;
    n = 0;
    @(negedge clk);
    while (!d_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!d_req_ready) chk("d req_ready wait", d_req_ready, 1);
    d_req_valid = 1; d_req_we = we; d_req_size = sz; d_req_unsigned = uns;
    d_req_addr = addr; d_req_wdata = wd; d_req_rd = 5'd9;
    @(posedge clk); #1;
    d_req_valid = 0;
    e.rdata = erd; e.err = eerr;
    sb64.push_back(e);
    if (mem) begin
      @(negedge clk);
      chk("d mem_valid", d_mem_valid, 1);
      chk("d mem_addr", d_mem_addr, maddr);
      chk("d mem_wdata", d_mem_wdata, mwd);
      chk("d mem_wmask", d_mem_wmask, mwm);
      d_mem_ready = 1;
      @(negedge clk);
      d_mem_ready = 0; d_mem_rvalid = 1; d_mem_rdata = mrd;
      @(negedge clk);
      d_mem_rvalid = 0;
    end
    n = 0;
    while (sb64.size() != 0 && n < 40) begin @(negedge clk); n++; end
    if (sb64.size() != 0) chk("d response wait", sb64.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req_ready"}, req_ready, 0);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " mem_valid"}, mem_valid, 0);
    chk({tag, " mem_cmd"}, {mem_we, mem_wmask, mem_addr}, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " resp_fields"}, {resp_rdata, resp_rd, resp_err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    d_req_valid = 0; d_req_we = 0; d_req_size = 0; d_req_unsigned = 0; d_req_addr = 0;
    d_req_wdata = 0; d_req_rd = 0;
    d_mem_ready = 0; d_mem_rvalid = 0; d_mem_rdata = 0; d_mem_err = 0;
    cfg_ready = 1; cfg_delay = 0; cfg_rdata = 32'h80FF1234; cfg_err = 0;
    #3 reset = 0;
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk("req_ready after reset", req_ready, 1);

    // loads and stores on the 32-bit path
    issue(0, 2'd0, 1, 32'h80000003, 0, 5'd1, 32'h00000080, 0, 2, 1, 32'h80000000, 0, 4'h0, 1);
    issue(0, 2'd1, 0, 32'h80000002, 0, 5'd2, 32'hFFFF80FF, 0, 2, 1, 32'h80000000, 0, 4'h0, 1);
    cfg_rdata = 32'hFFFFFFFF;
    issue(1, 2'd0, 0, 32'h80000001, 32'h000000AB, 5'd3, 0, 0, 2, 1, 32'h80000000, 32'h0000AB00, 4'b0010, 1);
    issue(1, 2'd2, 0, 32'h80000004, 32'hDEADBEEF, 5'd4, 0, 0, 2, 1, 32'h80000004, 32'hDEADBEEF, 4'hF, 1);
    cfg_rdata = 32'h80FF1234;
    issue(0, 2'd0, 0, 32'h80000003, 0, 5'd5, 32'hFFFFFF80, 0, 2, 1, 32'h80000000, 0, 4'h0, 1);
    issue(0, 2'd1, 1, 32'h80000000, 0, 5'd6, 32'h00001234, 0, 2, 1, 32'h80000000, 0, 4'h0, 1);
    // bus error returns code 2 and no data
    cfg_err = 1;
    issue(0, 2'd2, 0, 32'h80000004, 0, 5'd7, 0, 2'd2, 2, 1, 32'h80000004, 0, 4'h0, 1);
    cfg_err = 0;
    // misaligned / illegal: one-cycle error, memory never sees a command
    issue(0, 2'd2, 0, 32'h80000002, 0, 5'd8, 0, 2'd1, 0, 0, 0, 0, 0, 1);
    issue(0, 2'd3, 0, 32'h80000000, 0, 5'd9, 0, 2'd1, 0, 0, 0, 0, 0, 1);
    issue(1, 2'd1, 0, 32'h80000003, 32'h1234, 5'd10, 0, 2'd1, 0, 0, 0, 0, 0, 1);
    // memory never accepts: timeout four cycles after entering ISSUE
    cfg_ready = 0;
    issue(0, 2'd2, 0, 32'h80000008, 0, 5'd11, 0, 2'd3, 4, 1, 32'h80000008, 0, 4'h0, 1);
    memq.delete();
    cfg_ready = 1;
    // completion in the timeout cycle wins
    cfg_delay = 2; cfg_rdata = 32'h11223344;
    issue(0, 2'd2, 0, 32'h80000010, 0, 5'd12, 32'h11223344, 0, 4, 1, 32'h80000010, 0, 4'h0, 1);
    // completion one cycle late: timeout, late beat ignored
    cfg_delay = 3;
    issue(0, 2'd2, 0, 32'h80000014, 0, 5'd13, 0, 2'd3, 4, 1, 32'h80000014, 0, 4'h0, 1);
    // reset while waiting for the read beat
    cfg_delay = 20;
    issue(0, 2'd2, 0, 32'h80000020, 0, 5'd14, 0, 0, 0, 1, 32'h80000020, 0, 4'h0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    #1 chk_reset_outs("midreset");
    repeat (2) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk("req_ready after midreset", req_ready, 1);
    chk("no pending mem cmd", memq.size(), 0);
    cfg_delay = 0; cfg_rdata = 32'h80FF1234;
    issue(0, 2'd0, 1, 32'h80000003, 0, 5'd15, 32'h00000080, 0, 2, 1, 32'h80000000, 0, 4'h0, 1);

    // 64-bit path
    issue64(0, 2'd3, 0, 32'h00000008, 0, 64'h8877665544332211, 0, 1,
            32'h00000008, 0, 8'h00, 64'h8877665544332211);
    issue64(1, 2'd2, 0, 32'h0000000C, 64'h00000000CAFEBABE, 0, 0, 1,
            32'h00000008, 64'hCAFEBABE00000000, 8'hF0, 64'h0);
    issue64(0, 2'd2, 0, 32'h0000000C, 0, 64'hFFFFFFFF88776655, 0, 1,
            32'h00000008, 0, 8'h00, 64'h8877665544332211);
    issue64(0, 2'd3, 0, 32'h0000000C, 0, 0, 2'd1, 0, 0, 0, 8'h00, 64'h0);

    n = 0;
    while ((sb.size() + sb64.size()) != 0 && n < 200) begin @(negedge clk); n++; end
    chk("scoreboards drained", sb.size() + sb64.size() + memq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
